// File: rtl/mprj_pad_ctrl.sv
// Per-pad configuration for the user-project GPIO array: shadow/active config words,
// a one-pad-per-cycle commit sweep, pad control decode and a 2-flop input synchronizer.
module mprj_pad_ctrl #(
    parameter int unsigned           TOTAL_PADS = 38,
    parameter int unsigned           CFG_BITS   = 13,
    parameter logic [CFG_BITS-1:0]   RESET_CFG  = CFG_BITS'(13'h0403)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [5:0]              cfg_addr,
    input  logic [CFG_BITS-1:0]     cfg_wdata,
    output logic [CFG_BITS-1:0]     cfg_rdata,
    output logic                    cfg_err,
    input  logic                    commit_req,
    output logic                    busy,
    output logic                    commit_done,
    input  logic [TOTAL_PADS-1:0]   mgmt_io_out,
    input  logic [TOTAL_PADS-1:0]   user_io_out,
    input  logic [TOTAL_PADS-1:0]   user_oeb,
    output logic [TOTAL_PADS-1:0]   pad_io_out,
    output logic [TOTAL_PADS-1:0]   pad_oeb,
    output logic [TOTAL_PADS-1:0]   pad_inp_dis,
    output logic [TOTAL_PADS-1:0]   pad_ib_mode_sel,
    output logic [TOTAL_PADS-1:0]   pad_vtrip_sel,
    output logic [TOTAL_PADS-1:0]   pad_slow_sel,
    output logic [TOTAL_PADS-1:0]   pad_holdover,
    output logic [TOTAL_PADS-1:0]   pad_analog_en,
    output logic [TOTAL_PADS-1:0]   pad_analog_sel,
    output logic [TOTAL_PADS-1:0]   pad_analog_pol,
    output logic [3*TOTAL_PADS-1:0] pad_dm,
    input  logic [TOTAL_PADS-1:0]   pad_io_in,
    output logic [TOTAL_PADS-1:0]   io_in_sync
);

    localparam int unsigned IDX_W    = 6;
    localparam logic [IDX_W-1:0] NUM_PADS = IDX_W'(TOTAL_PADS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_PADS - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                copy_en;
    logic                done_d;
    logic                addr_ok;
    logic                wr_ok;
    logic                err_d;
    logic [CFG_BITS-1:0] shadow [TOTAL_PADS];
    logic [CFG_BITS-1:0] active [TOTAL_PADS];
    logic [TOTAL_PADS-1:0] sync_ff1;

    assign addr_ok = (cfg_addr < NUM_PADS);
    assign wr_ok   = cfg_we && (state_q == IDLE) && addr_ok;
    assign err_d   = cfg_we && !wr_ok;

    // Sweep state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state; the index never advances past the last pad
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        copy_en = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit_req) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                copy_en = (idx_q <= LAST_IDX);
                if (idx_q >= LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered status and readback
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            commit_done <= 1'b0;
            cfg_err     <= 1'b0;
            cfg_rdata   <= '0;
        end else begin
            busy        <= (state_d == SWEEP);
            commit_done <= done_d;
            cfg_err     <= err_d;
            cfg_rdata   <= addr_ok ? active[cfg_addr] : '0;
        end
    end

    // Shadow and active configuration storage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(TOTAL_PADS); i++) begin
                shadow[i] <= RESET_CFG;
                active[i] <= RESET_CFG;
            end
        end else begin
            if (wr_ok) shadow[cfg_addr] <= cfg_wdata;
            if (copy_en) active[idx_q] <= shadow[idx_q];
        end
    end

    // Input synchronizer, no combinational pad-to-core path
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_ff1   <= '0;
            io_in_sync <= '0;
        end else begin
            sync_ff1   <= pad_io_in;
            io_in_sync <= sync_ff1;
        end
    end

    // Pad pin decode from the active word; mgmt_en selects who owns oeb/io_out
    for (genvar i = 0; i < int'(TOTAL_PADS); i++) begin : g_pad
        logic [CFG_BITS-1:0] cfg;
        assign cfg                  = active[i];
        assign pad_oeb[i]           = cfg[0] ? cfg[1] : user_oeb[i];
        assign pad_io_out[i]        = cfg[0] ? mgmt_io_out[i] : user_io_out[i];
        assign pad_holdover[i]      = cfg[2];
        assign pad_inp_dis[i]       = cfg[3];
        assign pad_ib_mode_sel[i]   = cfg[4];
        assign pad_analog_en[i]     = cfg[5];
        assign pad_analog_sel[i]    = cfg[6];
        assign pad_analog_pol[i]    = cfg[7];
        assign pad_slow_sel[i]      = cfg[8];
        assign pad_vtrip_sel[i]     = cfg[9];
        assign pad_dm[3*i +: 3]     = cfg[12:10];
    end

endmodule

// File: tb/tb_mprj_pad_ctrl.sv
// Directed self-checking bench for mprj_pad_ctrl.
module tb_mprj_pad_ctrl;

    localparam int unsigned N  = 38;
    localparam int unsigned CB = 13;

    logic           clock = 1'b0;
    logic           reset;
    logic           cfg_we;
    logic [5:0]     cfg_addr;
    logic [CB-1:0]  cfg_wdata;
    logic [CB-1:0]  cfg_rdata;
    logic           cfg_err;
    logic           commit_req;
    logic           busy;
    logic           commit_done;
    logic [N-1:0]   mgmt_io_out, user_io_out, user_oeb;
    logic [N-1:0]   pad_io_out, pad_oeb, pad_inp_dis, pad_ib_mode_sel, pad_vtrip_sel;
    logic [N-1:0]   pad_slow_sel, pad_holdover, pad_analog_en, pad_analog_sel, pad_analog_pol;
    logic [3*N-1:0] pad_dm;
    logic [N-1:0]   pad_io_in, io_in_sync;

    int errors = 0;
    int checks = 0;

    mprj_pad_ctrl dut (
        .clock(clock), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
        .commit_req(commit_req), .busy(busy), .commit_done(commit_done),
        .mgmt_io_out(mgmt_io_out), .user_io_out(user_io_out), .user_oeb(user_oeb),
        .pad_io_out(pad_io_out), .pad_oeb(pad_oeb), .pad_inp_dis(pad_inp_dis),
        .pad_ib_mode_sel(pad_ib_mode_sel), .pad_vtrip_sel(pad_vtrip_sel),
        .pad_slow_sel(pad_slow_sel), .pad_holdover(pad_holdover),
        .pad_analog_en(pad_analog_en), .pad_analog_sel(pad_analog_sel),
        .pad_analog_pol(pad_analog_pol), .pad_dm(pad_dm),
        .pad_io_in(pad_io_in), .io_in_sync(io_in_sync)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3*N-1:0] dm_reset;
    logic [N-1:0]   all_ones;
    int busy_cnt, done_cnt, done_at, dm_change_at, glitch_cnt;

    initial begin
        all_ones = '1;
        dm_reset = {N{3'b001}};
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; commit_req = 1'b0;
        mgmt_io_out = 38'h15_5555_5555; user_io_out = 38'h2A_0F0F_0F0F; user_oeb = '1;
        pad_io_in = '0;
        #1;

        // Reset state
        chk("rst_oeb", pad_oeb, all_ones);
        chk("rst_dm", pad_dm, dm_reset);
        chk("rst_inp_dis", pad_inp_dis, 0);
        chk("rst_analog_en", pad_analog_en, 0);
        chk("rst_io_out", pad_io_out, 38'h15_5555_5555);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", cfg_rdata, 0);
        chk("rst_sync", io_in_sync, 0);
        tick();
        reset = 1'b0;
        cfg_addr = 6'd7;
        tick();
        chk("rd_pad7_reset", cfg_rdata, 13'h0403);
        cfg_addr = 6'd37;
        tick();
        chk("rd_pad37_reset", cfg_rdata, 13'h0403);
        cfg_addr = 6'd40;
        tick();
        chk("rd_oob_zero", cfg_rdata, 0);

        // Pad 5 into user mode, then a commit sweep
        cfg_we = 1'b1; cfg_addr = 6'd5; cfg_wdata = 13'h1800;
        tick();
        cfg_we = 1'b0;
        chk("wr_ok_no_err", cfg_err, 0);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        chk("busy_start", busy, 1);
        busy_cnt = 1; done_cnt = 0; done_at = -1; dm_change_at = -1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (busy) busy_cnt++;
            if (commit_done) begin done_cnt++; done_at = k; end
            if (dm_change_at < 0 && pad_dm[17:15] == 3'b110) dm_change_at = k;
        end
        chk("busy_len", busy_cnt, 38);
        chk("done_count", done_cnt, 1);
        chk("done_cycle", done_at, 38);
        chk("pad5_dm_cycle", dm_change_at, 6);
        chk("pad4_dm_kept", pad_dm[14:12], 3'b001);
        chk("pad4_oeb_kept", pad_oeb[4], 1);
        user_io_out[5] = 1'b1; user_oeb[5] = 1'b0; #1;
        chk("pad5_user_out_1", pad_io_out[5], 1);
        chk("pad5_user_oeb_0", pad_oeb[5], 0);
        user_io_out[5] = 1'b0; user_oeb[5] = 1'b1; #1;
        chk("pad5_user_out_0", pad_io_out[5], 0);
        chk("pad5_user_oeb_1", pad_oeb[5], 1);
        cfg_addr = 6'd5;
        tick();
        chk("rd_pad5", cfg_rdata, 13'h1800);

        // Rejected writes: during busy and out of range
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        cfg_we = 1'b1; cfg_addr = 6'd3; cfg_wdata = 13'h0000;
        tick();
        cfg_we = 1'b0;
        chk("err_busy_pulse", cfg_err, 1);
        tick();
        chk("err_busy_clear", cfg_err, 0);
        for (int k = 0; k < 100 && busy; k++) tick();
        chk("idle_wait1", busy, 0);
        cfg_we = 1'b1; cfg_addr = 6'd40; cfg_wdata = 13'h0000;
        tick();
        cfg_we = 1'b0;
        chk("err_oob_pulse", cfg_err, 1);
        tick();
        chk("err_oob_clear", cfg_err, 0);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        for (int k = 0; k < 100 && busy; k++) tick();
        chk("idle_wait2", busy, 0);
        cfg_addr = 6'd3;
        tick();
        chk("rd_pad3_unchanged", cfg_rdata, 13'h0403);
        chk("pad3_oeb_unchanged", pad_oeb[3], 1);

        // Write plus held commit_req in the same cycle; second sweep back-to-back
        cfg_we = 1'b1; cfg_addr = 6'd6; cfg_wdata = 13'h0002; commit_req = 1'b1;
        tick();
        cfg_we = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (commit_done) break;
        end
        chk("hold_done_seen", commit_done, 1);
        tick();
        commit_req = 1'b0;
        chk("hold_restart_busy", busy, 1);
        busy_cnt = 1; done_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            commit_req = (k == 10);
            tick();
            if (busy) busy_cnt++;
            if (commit_done) done_cnt++;
        end
        commit_req = 1'b0;
        chk("sweep2_busy_len", busy_cnt, 38);
        chk("sweep2_done_count", done_cnt, 1);
        cfg_addr = 6'd6;
        tick();
        chk("rd_pad6_same_cycle_wr", cfg_rdata, 13'h0002);
        user_oeb[6] = 1'b0; #1;
        chk("pad6_user_oeb", pad_oeb[6], 0);

        // Reset in the middle of a sweep of all-zero shadows
        user_oeb = '0;
        for (int i = 0; i < int'(N); i++) begin
            cfg_we = 1'b1; cfg_addr = 6'(i); cfg_wdata = 13'h0000;
            tick();
        end
        cfg_we = 1'b0;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        repeat (20) tick();
        chk("midsweep_oeb", pad_oeb, {18'h3FFFF, 20'h00000});
        chk("midsweep_busy", busy, 1);
        #3 reset = 1'b1;
        #1;
        chk("arst_oeb", pad_oeb, all_ones);
        chk("arst_dm", pad_dm, dm_reset);
        chk("arst_busy", busy, 0);
        chk("arst_done", commit_done, 0);
        tick();
        reset = 1'b0;
        done_cnt = 0; busy_cnt = 0;
        cfg_addr = 6'd0;
        for (int k = 0; k < 45; k++) begin
            tick();
            if (commit_done) done_cnt++;
            if (busy) busy_cnt++;
        end
        chk("post_rst_no_done", done_cnt, 0);
        chk("post_rst_no_busy", busy_cnt, 0);
        chk("rd_pad0_reverted", cfg_rdata, 13'h0403);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        for (int k = 0; k < 100 && busy; k++) tick();
        cfg_addr = 6'd0;
        tick();
        chk("shadow0_reverted", cfg_rdata, 13'h0403);

        // Synchronizer latency and glitch
        pad_io_in[0] = 1'b1;
        tick();
        chk("sync_lat1", io_in_sync[0], 0);
        tick();
        chk("sync_lat2", io_in_sync[0], 1);
        chk("sync_others", io_in_sync[N-1:1], 0);
        pad_io_in[0] = 1'b0;
        repeat (3) tick();
        chk("sync_low", io_in_sync[0], 0);
        glitch_cnt = 0;
        pad_io_in[0] = 1'b1;
        tick();
        glitch_cnt += int'(io_in_sync[0]);
        pad_io_in[0] = 1'b0;
        repeat (5) begin
            tick();
            glitch_cnt += int'(io_in_sync[0]);
        end
        chk("sync_glitch_width", (glitch_cnt <= 1), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
